// File: rtl/pkt_header_parser_if.sv
// Packet stream interface for pkt_header_parser: upstream word/ctrl/wr with
// ready, registered downstream word, and the word-aligned sideband.
// master: the surrounding environment (FIFO read side + accelerator).
// slave:  the parser itself.
interface pkt_header_parser_if #(
  parameter int unsigned DWIDTH     = 64,
  parameter int unsigned CTRL_WIDTH = DWIDTH / 8
);
  logic [DWIDTH-1:0]     in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  in_rdy;
  logic [DWIDTH-1:0]     out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;
  logic [1:0]            path_sel;
  logic                  inside_payload;
  logic [15:0]           data_count;
  logic                  hdr_err;

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr,
           path_sel, inside_payload, data_count, hdr_err
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr,
           path_sel, inside_payload, data_count, hdr_err
  );
endinterface

// File: rtl/pkt_header_parser.sv
// Packet header parser in front of the crypto accelerator. Frames the
// word/ctrl stream into module header, packet header and payload, forwards
// each accepted word with one cycle of latency, and attaches path_sel,
// inside_payload, data_count and hdr_err aligned with the forwarded word.
// Optional macro PKT_PARSER_STATS_EN adds saturating pkt_count/err_count.
module pkt_header_parser #(
  parameter int unsigned DWIDTH     = 64,
  parameter int unsigned CTRL_WIDTH = DWIDTH / 8,
  parameter int unsigned HDR_WORDS  = 3,
  parameter logic [15:0] ENC_TAG    = 16'hE0E0,
  parameter logic [15:0] DEC_TAG    = 16'hD0D0
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  pkt_header_parser_if.slave bus
`ifdef PKT_PARSER_STATS_EN
  ,
  output logic [31:0]        pkt_count,
  output logic [15:0]        err_count
`endif
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned PKT_W = 32;
  localparam int unsigned ERR_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOD_HDR = 2'd1,
    HDR     = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] hdr_idx;
  logic [1:0]       tag_path;
  logic [CNT_W-1:0] pay_cnt;

  logic [DWIDTH-1:0]     word_c;
  logic [CTRL_WIDTH-1:0] ctrl_c;
  logic                  accept_c;
  logic                  ctrl_zero_c;
  logic                  ctrl_ones_c;
  logic                  hdr0_c;
  logic                  err_c;
  logic                  eop_c;
  logic [1:0]            tag_dec_c;

  // Ready is a straight pass-through; downstream absorbs the in-flight word.
  assign bus.in_rdy  = bus.out_rdy;
  assign word_c      = bus.in_data;
  assign ctrl_c      = bus.in_ctrl;
  assign accept_c    = bus.in_wr & bus.out_rdy;
  assign ctrl_zero_c = (ctrl_c == '0);
  assign ctrl_ones_c = (ctrl_c == '1);

  // Classify the incoming word against the current framing state.
  always_comb begin
    hdr0_c    = 1'b0;
    err_c     = 1'b0;
    eop_c     = 1'b0;
    tag_dec_c = 2'b00;
    if (word_c[15:0] == ENC_TAG) begin
      tag_dec_c = 2'b01;
    end else if (word_c[15:0] == DEC_TAG) begin
      tag_dec_c = 2'b10;
    end
    case (state)
      IDLE, MOD_HDR: begin
        hdr0_c = ctrl_zero_c;
        err_c  = !ctrl_zero_c && !ctrl_ones_c;
      end
      HDR:     err_c = !ctrl_zero_c;
      PAYLOAD: eop_c = !ctrl_zero_c;
      default: begin
        hdr0_c = 1'b0;
      end
    endcase
  end

  // Framing FSM plus registered word and sideband; all updates on acceptance.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state              <= IDLE;
      hdr_idx            <= '0;
      tag_path           <= 2'b00;
      pay_cnt            <= '0;
      bus.out_data       <= '0;
      bus.out_ctrl       <= '0;
      bus.out_wr         <= 1'b0;
      bus.path_sel       <= 2'b00;
      bus.inside_payload <= 1'b0;
      bus.data_count     <= '0;
      bus.hdr_err        <= 1'b0;
    end else begin
      bus.out_wr <= accept_c;
      if (accept_c) begin
        bus.out_data       <= word_c;
        bus.out_ctrl       <= ctrl_c;
        bus.hdr_err        <= err_c;
        bus.inside_payload <= (state == PAYLOAD);
        bus.data_count     <= (state == PAYLOAD) ? pay_cnt : '0;
        case (state)
          IDLE, MOD_HDR: begin
            if (hdr0_c) begin
              tag_path     <= tag_dec_c;
              bus.path_sel <= tag_dec_c;
              hdr_idx      <= IDX_W'(1);
              pay_cnt      <= '0;
              state        <= (HDR_WORDS == 1) ? PAYLOAD : HDR;
            end else begin
              bus.path_sel <= 2'b00;
              state        <= ctrl_ones_c ? MOD_HDR : IDLE;
            end
          end
          HDR: begin
            bus.path_sel <= tag_path;
            if (err_c) begin
              state   <= IDLE;
              hdr_idx <= '0;
              pay_cnt <= '0;
            end else begin
              hdr_idx <= hdr_idx + IDX_W'(1);
              if (hdr_idx == IDX_W'(HDR_WORDS - 1)) begin
                state <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            bus.path_sel <= tag_path;
            if (eop_c) begin
              state   <= IDLE;
              hdr_idx <= '0;
              pay_cnt <= '0;
            end else if (pay_cnt != '1) begin
              pay_cnt <= pay_cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef PKT_PARSER_STATS_EN
  // Saturating counts of completed packets and framing errors.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (accept_c) begin
      if (eop_c && (pkt_count != '1)) begin
        pkt_count <= pkt_count + PKT_W'(1);
      end
      if (err_c && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pkt_header_parser.sv
// Self-checking bench for pkt_header_parser: directed scenarios plus random
// packets with random flow control, checked against a packet-level model.
// Honours PKT_PARSER_STATS_EN when defined.
module tb_pkt_header_parser;

  localparam int unsigned HDR_WORDS = 3;
  localparam logic [15:0] ENC = 16'hE0E0;
  localparam logic [15:0] DEC = 16'hD0D0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pkt_header_parser_if pif ();

`ifdef PKT_PARSER_STATS_EN
  logic [31:0] pkt_count;
  logic [15:0] err_count;
`endif

  pkt_header_parser dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (pif)
`ifdef PKT_PARSER_STATS_EN
    ,
    .pkt_count (pkt_count),
    .err_count (err_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Packet-level model: m_hdr = -1 outside a packet, else header words seen.
  int         m_hdr = -1;
  int         m_pay = 0;
  logic [1:0] m_tag = 2'b00;
  int         m_pkts = 0;
  int         m_errs = 0;
  logic [1:0]  e_path = 2'b00;
  logic        e_inside = 1'b0;
  logic [15:0] e_count = 16'h0;
  logic        e_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd();
    return {$urandom, $urandom};
  endfunction

  function automatic void model_clear();
    m_hdr = -1; m_pay = 0; m_pkts = 0; m_errs = 0;
    e_path = 2'b00; e_inside = 1'b0; e_count = 16'h0; e_err = 1'b0;
  endfunction

  function automatic void model(input logic [7:0] c, input logic [63:0] d);
    logic [15:0] t;
    t = d[15:0];
    e_path = 2'b00; e_inside = 1'b0; e_count = 16'h0; e_err = 1'b0;
    if (m_hdr < 0) begin
      if (c == 8'h00) begin
        m_tag = (t == ENC) ? 2'b01 : (t == DEC) ? 2'b10 : 2'b00;
        m_hdr = 1;
        m_pay = 0;
        e_path = m_tag;
      end else if (c != 8'hFF) begin
        e_err = 1'b1;
        m_errs++;
      end
    end else if (m_hdr < int'(HDR_WORDS)) begin
      e_path = m_tag;
      if (c == 8'h00) m_hdr++;
      else begin
        e_err = 1'b1;
        m_errs++;
        m_hdr = -1;
      end
    end else begin
      e_path = m_tag;
      e_inside = 1'b1;
      e_count = (m_pay > 65535) ? 16'hFFFF : 16'(m_pay);
      m_pay++;
      if (c != 8'h00) begin
        m_hdr = -1;
        m_pay = 0;
        m_pkts++;
      end
    end
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, pif.out_data, 64'h0);
    chk({tag, "_ctrl"}, 64'(pif.out_ctrl), 64'h0);
    chk({tag, "_wr"}, 64'(pif.out_wr), 64'h0);
    chk({tag, "_path"}, 64'(pif.path_sel), 64'h0);
    chk({tag, "_inside"}, 64'(pif.inside_payload), 64'h0);
    chk({tag, "_count"}, 64'(pif.data_count), 64'h0);
    chk({tag, "_err"}, 64'(pif.hdr_err), 64'h0);
`ifdef PKT_PARSER_STATS_EN
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'h0);
    chk({tag, "_err_count"}, 64'(err_count), 64'h0);
`endif
  endtask

  // One clock of stimulus, then check the registered outputs after the edge.
  task automatic step(input logic wr, input logic [7:0] c, input logic [63:0] d, input logic rdy);
    logic acc;
    @(negedge clk);
    pif.in_wr = wr; pif.in_ctrl = c; pif.in_data = d; pif.out_rdy = rdy;
    #1;
    chk("in_rdy", 64'(pif.in_rdy), 64'(rdy));
    acc = wr & rdy;
    if (acc) model(c, d);
    @(posedge clk);
    #1;
    chk("out_wr", 64'(pif.out_wr), 64'(acc));
    if (acc) begin
      chk("out_data", pif.out_data, d);
      chk("out_ctrl", 64'(pif.out_ctrl), 64'(c));
    end
    chk("path_sel", 64'(pif.path_sel), 64'(e_path));
    chk("inside_payload", 64'(pif.inside_payload), 64'(e_inside));
    chk("data_count", 64'(pif.data_count), 64'(e_count));
    chk("hdr_err", 64'(pif.hdr_err), 64'(e_err));
`ifdef PKT_PARSER_STATS_EN
    chk("pkt_count", 64'(pkt_count), 64'(m_pkts));
    chk("err_count", 64'(err_count), 64'(m_errs));
`endif
  endtask

  // Deliver one word; with drop>0 inserts random idle and stall cycles.
  task automatic put(input logic [7:0] c, input logic [63:0] d, input int drop);
    logic wr, rdy;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      wr  = (drop == 0) || ($urandom_range(0, 7) != 0) || (i == 29);
      rdy = (drop == 0) || (int'($urandom_range(0, 99)) >= drop) || (i == 29);
      if (wr) step(1'b1, c, d, rdy);
      else step(1'b0, 8'($urandom), rnd(), rdy);
      done = wr & rdy;
    end
  endtask

  task automatic rand_pkt(input int drop, input bit allow_err);
    int nmod, npay, bad_at, sel;
    logic [63:0] w;
    logic [7:0] eop;
    nmod = int'($urandom_range(0, 2));
    for (int i = 0; i < nmod; i++) put(8'hFF, rnd(), drop);
    if (allow_err && ($urandom_range(0, 7) == 0)) put(8'h04, rnd(), drop);
    sel = int'($urandom_range(0, 3));
    w = rnd();
    case (sel)
      0: w[15:0] = ENC;
      1: w[15:0] = DEC;
      default: w[15:0] = 16'($urandom);
    endcase
    bad_at = (allow_err && ($urandom_range(0, 4) == 0)) ?
             int'($urandom_range(1, HDR_WORDS - 1)) : 0;
    put(8'h00, w, drop);
    for (int h = 1; h < int'(HDR_WORDS); h++) begin
      if (h == bad_at) begin
        put(8'($urandom_range(1, 254)), rnd(), drop);
        return;
      end
      put(8'h00, rnd(), drop);
    end
    npay = int'($urandom_range(1, 6));
    for (int p = 0; p < npay - 1; p++) put(8'h00, rnd(), drop);
    eop = 8'($urandom_range(1, 255));
    put(eop, rnd(), drop);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pif.in_wr = 1'b0;
    #2 rst_n = 1'b0;
    model_clear();
    #1 check_zero("reset_pulse");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] w;
    pif.in_wr = 1'b0; pif.in_ctrl = 8'h00; pif.in_data = 64'h0; pif.out_rdy = 1'b1;
    model_clear();
    #12;
    check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // ENC packet with module header: 3 header words, 2 payload, EOP 0x80
    put(8'hFF, rnd(), 0);
    w = rnd(); w[15:0] = ENC;
    put(8'h00, w, 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    chk("enc_hdr2_inside", 64'(pif.inside_payload), 64'h0);
    put(8'h00, rnd(), 0);
    chk("enc_pay0_count", 64'(pif.data_count), 64'h0);
    put(8'h00, rnd(), 0);
    put(8'h80, rnd(), 0);
    chk("enc_eop_path", 64'(pif.path_sel), 64'h1);
    chk("enc_eop_count", 64'(pif.data_count), 64'h2);

    // DEC packet without module header, single EOP payload word
    w = rnd(); w[15:0] = DEC;
    put(8'h00, w, 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    put(8'h01, rnd(), 0);
    chk("dec_eop_path", 64'(pif.path_sel), 64'h2);
    chk("dec_eop_count", 64'(pif.data_count), 64'h0);
    w = rnd(); w[15:0] = 16'h1234;
    put(8'h00, w, 0);
    chk("other_tag_path", 64'(pif.path_sel), 64'h0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    put(8'h40, rnd(), 0);

    // Back-pressure mid-payload with in_wr held
    w = rnd(); w[15:0] = ENC;
    put(8'h00, w, 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    w = rnd();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h00, w, 1'b0);
    chk("bp_stall_wr", 64'(pif.out_wr), 64'h0);
    put(8'h00, w, 0);
    chk("bp_resume_count", 64'(pif.data_count), 64'h2);
    put(8'h00, rnd(), 0);
    put(8'h02, rnd(), 0);
    chk("bp_eop_count", 64'(pif.data_count), 64'h4);

    // Framing error: EOP as header word 1, then a fresh header word 0
    w = rnd(); w[15:0] = ENC;
    put(8'h00, w, 0);
    put(8'h10, rnd(), 0);
    chk("ferr_pulse", 64'(pif.hdr_err), 64'h1);
    w = rnd(); w[15:0] = DEC;
    put(8'h00, w, 0);
    chk("ferr_recover_err", 64'(pif.hdr_err), 64'h0);
    chk("ferr_recover_path", 64'(pif.path_sel), 64'h2);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    put(8'h01, rnd(), 0);
    chk("ferr_recover_inside", 64'(pif.inside_payload), 64'h1);

    // Stray non-header word while idle
    put(8'h08, rnd(), 0);
    chk("stray_err", 64'(pif.hdr_err), 64'h1);

    // Asynchronous reset mid-payload, then a fresh packet
    w = rnd(); w[15:0] = ENC;
    put(8'h00, w, 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    do_reset();
    w = rnd(); w[15:0] = DEC;
    put(8'h00, w, 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    chk("post_reset_count", 64'(pif.data_count), 64'h0);
    put(8'h20, rnd(), 0);
    chk("post_reset_eop_count", 64'(pif.data_count), 64'h1);

    // data_count saturation on a very long payload
    w = rnd(); w[15:0] = ENC;
    put(8'h00, w, 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    for (int i = 0; i < 65540; i++) put(8'h00, rnd(), 0);
    chk("sat_count", 64'(pif.data_count), 64'hFFFF);
    put(8'h80, rnd(), 0);
    chk("sat_eop_count", 64'(pif.data_count), 64'hFFFF);
    w = rnd(); w[15:0] = DEC;
    put(8'h00, w, 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    put(8'h00, rnd(), 0);
    chk("after_sat_count", 64'(pif.data_count), 64'h0);
    put(8'h01, rnd(), 0);

    // Random packets, errors and flow control
    for (int p = 0; p < 150; p++) rand_pkt(25, 1'b1);

`ifdef PKT_PARSER_STATS_EN
    // Three good packets and one header-error packet from reset
    do_reset();
    for (int p = 0; p < 3; p++) rand_pkt(0, 1'b0);
    w = rnd(); w[15:0] = ENC;
    put(8'h00, w, 0);
    put(8'h10, rnd(), 0);
    chk("stats_pkt_count", 64'(pkt_count), 64'd3);
    chk("stats_err_count", 64'(err_count), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_header_parser.md
Name: pkt_header_parser

Overview:
- Stage directly upstream of the HW accelerator; sits between the input FIFO SRAM read side and the accelerator.
- Frames the 64-bit word/ctrl packet stream and classifies each word as module header, packet header or payload.
- Forwards every word with one register of latency, plus word-aligned sideband: path_sel, inside_payload and data_count.
- The accelerator consumes these sideband signals to route and encrypt/decrypt the payload.

Parameters:
- DWIDTH, 64, data word width.
- CTRL_WIDTH, DWIDTH/8, ctrl width (one bit per byte).
- HDR_WORDS, 3, number of packet-header words (ctrl==0) before payload; legal range 1..15.
- ENC_TAG, 16'hE0E0, header-word-0 tag selecting the encrypt path.
- DEC_TAG, 16'hD0D0, header-word-0 tag selecting the decrypt path.

Ports:
- i_clock  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- in_data  in  DWIDTH  upstream word.
- in_ctrl  in  CTRL_WIDTH  upstream ctrl.
- in_wr  in  1  upstream write strobe.
- in_rdy  out  1  block can accept a word this cycle.
- out_data  out  DWIDTH  registered word.
- out_ctrl  out  CTRL_WIDTH  registered ctrl.
- out_wr  out  1  registered write strobe.
- out_rdy  in  1  downstream can accept.
- path_sel  out  2  00 ALU, 01 encrypt, 10 decrypt; aligned with out_data.
- inside_payload  out  1  out word is payload.
- data_count  out  16  0-based payload word index of the out word.
- hdr_err  out  1  one-cycle framing-error pulse, aligned with the offending out word.

Behaviour:
- Clock and reset: i_clock only. i_reset_n is asynchronous and active-low, and fully asynchronous clear applies to every register.
- Reset values: out_data 0, out_ctrl 0, out_wr 0, path_sel 00, inside_payload 0, data_count 0, hdr_err 0, state IDLE, hdr_idx 0.
- Accept and latency:
  - in_rdy = out_rdy (combinational). A word is accepted when in_wr & in_rdy.
  - The accepted word appears on out_* one cycle later with out_wr=1, so latency is 1.
  - out_wr is 0 in every cycle with no acceptance.
- Flow control and ignored writes:
  - Downstream must absorb one word after dropping out_rdy, per the nearly-full convention.
  - in_wr while in_rdy=0 is ignored: no state change, no output.
- Sideband registers: path_sel, inside_payload, data_count and hdr_err update only on accepted words, and otherwise hold.
- FSM, evaluated on each accepted word, with c=in_ctrl:
  - IDLE:
    - c==all-ones: go to MOD_HDR.
    - c==0: header word 0; latch tag; hdr_idx=1; go to PAYLOAD if HDR_WORDS==1, else HDR.
    - Other c: pass the word, hdr_err=1, stay IDLE.
  - MOD_HDR:
    - c==all-ones: stay.
    - c==0: header word 0, same as in IDLE.
    - Other c: hdr_err=1, go to IDLE.
  - HDR:
    - c==0: hdr_idx++. Go to PAYLOAD when this word is header word HDR_WORDS-1.
    - c!=0 (EOP inside header): hdr_err=1, go to IDLE.
  - PAYLOAD:
    - c==0: payload word.
    - c!=0: last (partial) payload word, then go to IDLE.
- Tag decode on header word 0, using in_data[15:0]:
  - ENC_TAG gives 01.
  - DEC_TAG gives 10.
  - Anything else gives 00.
- path_sel output:
  - Decoded value is presented from header word 0 through the EOP word inclusive.
  - 00 on module-header words and on stray or idle words.
  - A header-error packet drops to 00 with the first word after the error.
- inside_payload output: 1 exactly for words accepted in PAYLOAD, including the EOP word; 0 otherwise.
- data_count output:
  - 0 for non-payload words.
  - For payload words, the count of earlier payload words in the packet.
  - Saturates at 16'hFFFF and never wraps.
  - Internal counter clears on entering IDLE.
- Back-to-back packets: a new header/module-header word the cycle after EOP is legal and parsed as a fresh packet.
- Reset mid-packet: immediate return to IDLE. The next word is parsed as a packet start; a partial remainder is handled by the IDLE rules (hdr_err on stray EOP).

Optional Feature:
- PKT_PARSER_STATS_EN.
- When defined:
  - Adds output pkt_count[31:0], which increments on each accepted PAYLOAD-state EOP word.
  - Adds output err_count[15:0], which increments on each hdr_err pulse.
  - Both counters saturate and are reset to 0.
- When undefined: these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Tag ENC_TAG, small packet:
  - Stimulus: ctrl FF, then 3 words ctrl 00 (hdr0 data[15:0]=E0E0), then 2 words ctrl 00, then EOP ctrl 0x80; out_rdy=1.
  - Expect: outputs one cycle later; path_sel 00,01,01,01,01,01,01; inside_payload 0,0,0,0,1,1,1; data_count 0,0,0,0,0,1,2; hdr_err never.
- Tag DEC_TAG, no module header: hdr0 D0D0, HDR_WORDS=3, 1 payload word with ctrl 0x01 → path_sel 10 on all 4 words; payload data_count 0; next packet with tag 1234 → path_sel 00.
- Back-pressure: drop out_rdy for 5 cycles mid-payload while in_wr held → in_rdy=0, out_wr=0 from the following cycle; no word lost or duplicated; data_count continues contiguously.
- Framing error: EOP ctrl 0x10 arrives as header word 1 → hdr_err=1 for that out word; next word ctrl 00 treated as header word 0.
- Async reset: assert i_reset_n=0 mid-payload between clock edges → all outputs 0 immediately; after release, a fresh packet parses with data_count starting at 0.
- With PKT_PARSER_STATS_EN: 3 good packets plus 1 header-error packet → pkt_count=3, err_count=1.
